// File: rtl/fa_gl.sv
// rtl/fa_gl.sv - gate-level ripple full adder with a registered, valid-qualified result copy
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic ab;
  logic ac;
  logic bc;

  xor g_s  (s, a, b, ci);
  and g_ab (ab, a, b);
  and g_ac (ac, a, ci);
  and g_bc (bc, b, ci);
  or  g_co (co, ab, ac, bc);
endmodule

module fa_gl #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  input  logic             ip3,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             out_valid
);
  // c[i] is the carry into cell i; c[WIDTH] leaves the MSB cell.
  logic [WIDTH:0] c;

  assign c[0] = ip3;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (ip1[i]),
      .b  (ip2[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign carry = c[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q     <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum_q     <= sum;
      carry_q   <= carry;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fa_gl.sv
// tb/tb_fa_gl.sv - directed table-driven bench for fa_gl at WIDTH 1 and 8
module tb_fa_gl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic ip1_a, ip2_a, ip3_a, iv_a;
  logic sum_a, carry_a, sum_q_a, carry_q_a, ov_a;

  logic [7:0] ip1_b, ip2_b, sum_b, sum_q_b;
  logic ip3_b, iv_b, carry_b, carry_q_b, ov_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fa_gl #(.WIDTH(1)) dut1 (
    .ip1(ip1_a), .ip2(ip2_a), .ip3(ip3_a), .sum(sum_a), .carry(carry_a),
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a),
    .sum_q(sum_q_a), .carry_q(carry_q_a), .out_valid(ov_a)
  );

  fa_gl #(.WIDTH(8)) dut8 (
    .ip1(ip1_b), .ip2(ip2_b), .ip3(ip3_b), .sum(sum_b), .carry(carry_b),
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b),
    .sum_q(sum_q_b), .carry_q(carry_q_b), .out_valid(ov_b)
  );

  typedef struct packed {
    logic a;
    logic b;
    logic ci;
    logic co;
    logic s;
  } vec1_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec8_t;

  vec1_t v1[8];
  vec8_t v8[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    v1[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    v1[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    v1[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    v1[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    v1[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    v1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    v8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    v8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    v8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    v8[3] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    v8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    v8[5] = '{8'hA5, 8'h3C, 1'b1, 8'hE2, 1'b0};
    v8[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    v8[7] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};

    iv_a = 1'b0; iv_b = 1'b0;
    ip1_a = 1'b0; ip2_a = 1'b0; ip3_a = 1'b0;
    ip1_b = 8'h00; ip2_b = 8'h00; ip3_b = 1'b0;

    for (int i = 0; i < 8; i++) begin
      ip1_a = v1[i].a; ip2_a = v1[i].b; ip3_a = v1[i].ci;
      #2;
      chk($sformatf("w1_sum_%0d", i), {7'b0, sum_a}, {7'b0, v1[i].s});
      chk($sformatf("w1_carry_%0d", i), {7'b0, carry_a}, {7'b0, v1[i].co});
    end

    for (int i = 0; i < 8; i++) begin
      ip1_b = v8[i].a; ip2_b = v8[i].b; ip3_b = v8[i].ci;
      #2;
      chk($sformatf("w8_sum_%0d", i), sum_b, v8[i].s);
      chk($sformatf("w8_carry_%0d", i), {7'b0, carry_b}, {7'b0, v8[i].co});
    end

    // Reset held for two edges with valid, all-ones inputs.
    rst_n = 1'b0; iv_a = 1'b1; ip1_a = 1'b1; ip2_a = 1'b1; ip3_a = 1'b1;
    tick();
    tick();
    chk("rst_sum_q", {7'b0, sum_q_a}, 8'h00);
    chk("rst_carry_q", {7'b0, carry_q_a}, 8'h00);
    chk("rst_out_valid", {7'b0, ov_a}, 8'h00);
    chk("rst_comb_sum", {7'b0, sum_a}, 8'h01);
    chk("rst_comb_carry", {7'b0, carry_a}, 8'h01);

    rst_n = 1'b1; iv_a = 1'b1; ip1_a = 1'b1; ip2_a = 1'b1; ip3_a = 1'b0;
    tick();
    chk("cap_sum_q", {7'b0, sum_q_a}, 8'h00);
    chk("cap_carry_q", {7'b0, carry_q_a}, 8'h01);
    chk("cap_out_valid", {7'b0, ov_a}, 8'h01);

    iv_a = 1'b0; ip1_a = 1'b0; ip2_a = 1'b0; ip3_a = 1'b1;
    tick();
    chk("hold_out_valid", {7'b0, ov_a}, 8'h00);
    chk("hold_sum_q", {7'b0, sum_q_a}, 8'h00);
    chk("hold_carry_q", {7'b0, carry_q_a}, 8'h01);

    // Back-to-back captures: 001, 110, 111.
    iv_a = 1'b1; ip1_a = 1'b0; ip2_a = 1'b0; ip3_a = 1'b1;
    tick();
    chk("b2b0", {6'b0, carry_q_a, sum_q_a}, 8'h01);
    chk("b2b0_valid", {7'b0, ov_a}, 8'h01);
    ip1_a = 1'b1; ip2_a = 1'b1; ip3_a = 1'b0;
    tick();
    chk("b2b1", {6'b0, carry_q_a, sum_q_a}, 8'h02);
    chk("b2b1_valid", {7'b0, ov_a}, 8'h01);
    ip1_a = 1'b1; ip2_a = 1'b1; ip3_a = 1'b1;
    tick();
    chk("b2b2", {6'b0, carry_q_a, sum_q_a}, 8'h03);
    chk("b2b2_valid", {7'b0, ov_a}, 8'h01);
    iv_a = 1'b0;
    tick();
    chk("b2b_end_valid", {7'b0, ov_a}, 8'h00);

    // WIDTH=8 capture, then reset mid-stream wipes the result.
    iv_b = 1'b1; ip1_b = 8'hA5; ip2_b = 8'h3C; ip3_b = 1'b1;
    tick();
    chk("w8_cap_sum_q", sum_q_b, 8'hE2);
    chk("w8_cap_carry_q", {7'b0, carry_q_b}, 8'h00);
    chk("w8_cap_valid", {7'b0, ov_b}, 8'h01);
    ip1_b = 8'h80; ip2_b = 8'h80; ip3_b = 1'b0;
    tick();
    chk("w8_cap2_sum_q", sum_q_b, 8'h00);
    chk("w8_cap2_carry_q", {7'b0, carry_q_b}, 8'h01);
    ip1_b = 8'hFF; ip2_b = 8'hFF; ip3_b = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", {7'b0, ov_b}, 8'h00);
    chk("mid_rst_sum_q", sum_q_b, 8'h00);
    chk("mid_rst_carry_q", {7'b0, carry_q_b}, 8'h00);
    chk("mid_rst_comb_sum", sum_b, 8'hFF);
    chk("mid_rst_comb_carry", {7'b0, carry_b}, 8'h01);
    rst_n = 1'b1; iv_b = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
